// File: rtl/cache_array_arb.sv
// Arbiter for the shared L2 tag/state/data array port: fixed-priority snoops (SU),
// a starvation limiter for L1 requests (CD), held grants and a hold-time watchdog.
module cache_array_arb #(
   parameter  int STARVE_LIM = 4,
   parameter  int TO_CYC     = 256,
   localparam int TO_W       = $clog2(TO_CYC + 1),
   localparam int SC_W       = $clog2(STARVE_LIM + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cd_req,
   output logic            cd_gnt,
   input  logic            su_req,
   output logic            su_gnt,
   output logic            arr_sel,
   output logic            busy,
   output logic            to_err,
   output logic [SC_W-1:0] starve_cnt,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN_CD = 2'd1,
      ST_OWN_SU = 2'd2
   } state_t;

   state_t          r_st;
   state_t          w_st_nxt;
   logic [TO_W-1:0] r_hold;
   logic [SC_W-1:0] r_starve;
   logic            r_to_err;
   logic            r_blk_cd;
   logic            r_blk_su;
   logic            w_cd_eff;
   logic            w_su_eff;
   logic            w_starved;
   logic            w_hold_max;
   logic            w_timeout;

   // A requester cut off by the watchdog is invisible until it drops req once.
   assign w_cd_eff   = cd_req & ~r_blk_cd;
   assign w_su_eff   = su_req & ~r_blk_su;
   assign w_starved  = (r_starve == SC_W'(STARVE_LIM));
   assign w_hold_max = (r_hold == TO_W'(TO_CYC - 1));

   always_comb begin
      w_st_nxt  = r_st;
      w_timeout = 1'b0;
      case (r_st)
         ST_IDLE: begin
            if (w_cd_eff && w_su_eff) w_st_nxt = w_starved ? ST_OWN_CD : ST_OWN_SU;
            else if (w_cd_eff)        w_st_nxt = ST_OWN_CD;
            else if (w_su_eff)        w_st_nxt = ST_OWN_SU;
         end
         ST_OWN_CD: begin
            if (!cd_req) begin
               w_st_nxt = w_su_eff ? ST_OWN_SU : ST_IDLE;
            end else if (w_hold_max) begin
               w_st_nxt  = ST_IDLE;
               w_timeout = 1'b1;
            end
         end
         ST_OWN_SU: begin
            if (!su_req) begin
               w_st_nxt = w_cd_eff ? ST_OWN_CD : ST_IDLE;
            end else if (w_hold_max) begin
               w_st_nxt  = ST_IDLE;
               w_timeout = 1'b1;
            end
         end
         default: w_st_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st     <= ST_IDLE;
         r_hold   <= '0;
         r_starve <= '0;
         r_to_err <= 1'b0;
         r_blk_cd <= 1'b0;
         r_blk_su <= 1'b0;
      end else begin
         r_st <= w_st_nxt;

         if (w_st_nxt != r_st)   r_hold <= '0;
         else if (r_st != ST_IDLE) r_hold <= r_hold + 1'b1;

         // Only SU grants taken while CD is waiting count toward starvation.
         if (w_st_nxt == ST_OWN_SU && r_st != ST_OWN_SU) begin
            if (!cd_req)         r_starve <= '0;
            else if (!w_starved) r_starve <= r_starve + 1'b1;
         end else if (w_st_nxt == ST_OWN_CD && r_st != ST_OWN_CD) begin
            r_starve <= '0;
         end

         if (w_timeout) r_to_err <= 1'b1;

         if (w_timeout && r_st == ST_OWN_CD) r_blk_cd <= 1'b1;
         else if (!cd_req)                   r_blk_cd <= 1'b0;

         if (w_timeout && r_st == ST_OWN_SU) r_blk_su <= 1'b1;
         else if (!su_req)                   r_blk_su <= 1'b0;
      end
   end

   assign cd_gnt     = (r_st == ST_OWN_CD);
   assign su_gnt     = (r_st == ST_OWN_SU);
   assign arr_sel    = su_gnt;
   assign busy       = cd_gnt | su_gnt;
   assign to_err     = r_to_err;
   assign starve_cnt = r_starve;
   assign dbg_state  = r_st;

endmodule

// File: tb/tb_cache_array_arb.sv
// Directed and table-driven bench for cache_array_arb with default parameters.
module tb_cache_array_arb;

   localparam int STARVE_LIM = 4;
   localparam int TO_CYC     = 256;
   localparam int SC_W       = $clog2(STARVE_LIM + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cd_req;
   logic            su_req;
   logic            cd_gnt;
   logic            su_gnt;
   logic            arr_sel;
   logic            busy;
   logic            to_err;
   logic [SC_W-1:0] starve_cnt;
   logic [1:0]      dbg_state;

   int checks = 0;
   int errors = 0;

   cache_array_arb #(.STARVE_LIM(STARVE_LIM), .TO_CYC(TO_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cd_req     (cd_req),
      .cd_gnt     (cd_gnt),
      .su_req     (su_req),
      .su_gnt     (su_gnt),
      .arr_sel    (arr_sel),
      .busy       (busy),
      .to_err     (to_err),
      .starve_cnt (starve_cnt),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]      req;   // {cd_req, su_req} applied before the edge
      logic [1:0]      gnt;   // {cd_gnt, su_gnt} expected after the edge
      logic [SC_W-1:0] cnt;   // starve_cnt expected after the edge
   } vec_t;

   vec_t tbl [21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      cd_req = 1'b0;
      su_req = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Outputs packed as {cd_gnt, su_gnt, busy, arr_sel, starve_cnt}
   function automatic logic [31:0] pack_exp(input logic [1:0] g, input logic [SC_W-1:0] c);
      return {25'd0, g[1], g[0], g[1] | g[0], g[0], c};
   endfunction

   initial begin
      int n;
      logic pcd, psu;

      tbl = '{
         '{2'b10, 2'b10, 3'd0},  // lone CD request, granted next cycle
         '{2'b11, 2'b10, 3'd0},  // SU waits behind held CD grant
         '{2'b01, 2'b01, 3'd0},  // back-to-back handoff CD->SU
         '{2'b11, 2'b01, 3'd0},
         '{2'b10, 2'b10, 3'd0},  // handoff SU->CD
         '{2'b00, 2'b00, 3'd0},
         '{2'b11, 2'b01, 3'd1},  // contested decisions 1..4 go to SU
         '{2'b00, 2'b00, 3'd1},
         '{2'b11, 2'b01, 3'd2},
         '{2'b00, 2'b00, 3'd2},
         '{2'b11, 2'b01, 3'd3},
         '{2'b00, 2'b00, 3'd3},
         '{2'b11, 2'b01, 3'd4},
         '{2'b00, 2'b00, 3'd4},
         '{2'b11, 2'b10, 3'd0},  // 5th contested decision forced to CD
         '{2'b11, 2'b10, 3'd0},
         '{2'b01, 2'b01, 3'd0},
         '{2'b10, 2'b10, 3'd0},
         '{2'b00, 2'b00, 3'd0},
         '{2'b01, 2'b01, 3'd0},  // uncontested SU entry
         '{2'b00, 2'b00, 3'd0}
      };

      do_reset();
      check("reset_outputs", {cd_gnt, su_gnt, busy, arr_sel, to_err, 3'(starve_cnt)}, 32'd0);

      for (int i = 0; i < 21; i++) begin
         cd_req = tbl[i].req[1];
         su_req = tbl[i].req[0];
         step();
         check($sformatf("vec%0d", i), {25'd0, cd_gnt, su_gnt, busy, arr_sel, 3'(starve_cnt)},
               pack_exp(tbl[i].gnt, tbl[i].cnt));
      end
      check("no_to_err_after_table", to_err, 1'b0);

      // Watchdog: SU holds req far past the limit
      su_req = 1'b1;
      step();
      check("wd_grant", su_gnt, 1'b1);
      n = 0;
      while (su_gnt && n < 400) begin
         step();
         n++;
      end
      check("wd_release_cycles", n, TO_CYC);
      check("wd_to_err", to_err, 1'b1);
      for (int i = 0; i < 20; i++) step();
      check("wd_su_blocked", {su_gnt, busy}, 2'b00);
      cd_req = 1'b1;
      step();
      check("wd_cd_while_su_blocked", {cd_gnt, su_gnt}, 2'b10);
      cd_req = 1'b0;
      su_req = 1'b0;
      step();
      check("wd_idle", busy, 1'b0);
      su_req = 1'b1;
      step();
      check("wd_su_regrant", su_gnt, 1'b1);
      check("wd_to_err_sticky", to_err, 1'b1);
      su_req = 1'b0;
      step();

      // Asynchronous reset while SU owns the array with a nonzero starve count
      cd_req = 1'b1;
      su_req = 1'b1;
      step();
      check("pre_rst_state", {su_gnt, to_err, 3'(starve_cnt)}, {2'b11, 3'd1});
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", {cd_gnt, su_gnt, busy, arr_sel, to_err, 3'(starve_cnt)}, 32'd0);
      cd_req = 1'b0;
      su_req = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Random toggling with invariant checks
      for (int i = 0; i < 3000; i++) begin
         cd_req = 1'($urandom_range(0, 1));
         su_req = 1'($urandom_range(0, 1));
         pcd = cd_req;
         psu = su_req;
         step();
         if ((cd_gnt & su_gnt) || (busy !== (cd_gnt | su_gnt)) || (arr_sel !== su_gnt) ||
             (cd_gnt & ~pcd) || (su_gnt & ~psu))
            check($sformatf("rand_invariant_cyc%0d", i),
                  {cd_gnt, su_gnt, busy, arr_sel, pcd, psu}, {1'b0, 1'b0, 1'b0, 1'b0, pcd, psu});
         else
            checks++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
